// File: rtl/core_mem_responder_if.sv
// core_mem_responder_if: the core's instruction and data request ports as seen by the memory responder.
interface core_mem_responder_if;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;
    modport master (
        output instr_read, instr_mem_address, data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
        input  instr_mem_resp, instr_mem_rdata, data_mem_resp, data_mem_rdata
    );
    modport slave (
        input  instr_read, instr_mem_address, data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
        output instr_mem_resp, instr_mem_rdata, data_mem_resp, data_mem_rdata
    );
endinterface

// File: rtl/core_mem_responder.sv
// core_mem_responder: round-robin fixed-latency responder for the core's instr/data ports on one word array.
// Define MEM_ERR_CHK_EN to build the sticky protocol checker driving mem_err.
module core_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                clk,
    input  logic                rst,
    core_mem_responder_if.slave bus,
    output logic                mem_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic                  sel_data, is_wr, prio_data;
    logic [ADDR_WIDTH-1:0] idx, cur_idx;
    logic [3:0]            mbe;
    logic [31:0]           wdata, acc_addr;
    logic                  grant_data, accept, req_held, go_resp, cur_sel, cur_wr;
    logic [31:0]           mem [2**ADDR_WIDTH];
    always_comb begin
        grant_data = (bus.data_read | bus.data_write) & (prio_data | ~bus.instr_read);
        accept     = state == IDLE && (bus.instr_read | bus.data_read | bus.data_write);
        acc_addr   = grant_data ? bus.data_mem_address : bus.instr_mem_address;
        req_held   = sel_data ? (is_wr ? bus.data_write : bus.data_read) : bus.instr_read;
        cur_sel    = accept ? grant_data : sel_data;
        cur_wr     = accept ? grant_data & bus.data_write : is_wr;
        cur_idx    = accept ? acc_addr[ADDR_WIDTH+1:2] : idx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (accept ? (LATENCY == 1 ? RESP : BUSY) : IDLE)
                  : state == BUSY ? (!req_held ? IDLE : cnt == 4'd1 ? RESP : BUSY)
                  : IDLE;
    end
    always_comb begin
        go_resp            = state_nxt == RESP;
        bus.instr_mem_resp = state == RESP && !sel_data;
        bus.data_mem_resp  = state == RESP && sel_data;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt                 <= '0;
            sel_data            <= 1'b0;
            is_wr               <= 1'b0;
            prio_data           <= 1'b1;
            idx                 <= '0;
            mbe                 <= '0;
            wdata               <= '0;
            bus.instr_mem_rdata <= '0;
            bus.data_mem_rdata  <= '0;
        end else begin
            if (accept) begin
                sel_data  <= grant_data;
                is_wr     <= grant_data & bus.data_write;
                prio_data <= ~grant_data;
                idx       <= acc_addr[ADDR_WIDTH+1:2];
                mbe       <= bus.data_mbe;
                wdata     <= bus.data_mem_wdata;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            // rdata is captured on entry to RESP so it is valid during the resp pulse
            if (go_resp && !cur_sel) bus.instr_mem_rdata <= mem[cur_idx];
            if (go_resp && cur_sel && !cur_wr) bus.data_mem_rdata <= mem[cur_idx];
        end
    end
    // the store commits on the edge leaving RESP, so a reset during RESP still cancels it
    always_ff @(posedge clk) begin
        if (state == RESP && sel_data && is_wr)
            for (int i = 0; i < 4; i++)
                if (mbe[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
`ifdef MEM_ERR_CHK_EN
    logic [31:0] lat_addr;
    logic        err_now;
    always_comb begin
        err_now = (accept && ((grant_data && bus.data_read && bus.data_write)
                           || (acc_addr >> (ADDR_WIDTH + 2)) != '0
                           || (!grant_data && acc_addr[1:0] != 2'b00)))
               || (state == BUSY && (sel_data ? bus.data_mem_address : bus.instr_mem_address) != lat_addr);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_err  <= 1'b0;
            lat_addr <= '0;
        end else begin
            if (accept) lat_addr <= acc_addr;
            if (err_now) mem_err <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst && err_now) $error("core_mem_responder: protocol error at address %h", acc_addr);
    end
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[31:ADDR_WIDTH+2], acc_addr[1:0]};
    assign mem_err = 1'b0;
`endif
endmodule

// File: tb/tb_core_mem_responder.sv
// tb_core_mem_responder: directed and random transactions checked against a word-array reference model.
module tb_core_mem_responder;
    localparam int AW  = 10;
    localparam int LAT = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_err;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] model [2**AW];
    core_mem_responder_if bus ();
    core_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .mem_err(mem_err)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instr_read        = 1'b0;
        bus.instr_mem_address = '0;
        bus.data_read         = 1'b0;
        bus.data_write        = 1'b0;
        bus.data_mbe          = '0;
        bus.data_mem_address  = '0;
        bus.data_mem_wdata    = '0;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    function automatic void mstore(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        model[widx(a)] = (model[widx(a)] & ~mask) | (d & mask);
    endfunction

    // One isolated transaction: resp must appear exactly LAT cycles after accept, on its own port only.
    task automatic xact(input string tag, input bit is_d, input bit rd, input bit wr,
                        input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        logic [7:0]  hit_mine = '0;
        logic [7:0]  hit_other = '0;
        logic [31:0] rd_prev = bus.data_mem_rdata;
        logic [31:0] exp_rd = model[widx(a)];
        bit          store = is_d && wr;
        if (is_d) begin
            bus.data_read = rd; bus.data_write = wr; bus.data_mbe = m;
            bus.data_mem_address = a; bus.data_mem_wdata = d;
        end else begin
            bus.instr_read = 1'b1; bus.instr_mem_address = a;
        end
        for (int k = 1; k <= LAT + 1; k++) begin
            step();
            if (is_d ? bus.data_mem_resp : bus.instr_mem_resp) hit_mine[k-1] = 1'b1;
            if (is_d ? bus.instr_mem_resp : bus.data_mem_resp) hit_other[k-1] = 1'b1;
            if (k == 1) begin
                bus.data_mbe = 4'($urandom);
                bus.data_mem_wdata = $urandom;
                bus.data_mem_address = {$urandom_range(0, 255), 2'b00};
                bus.instr_mem_address = {$urandom_range(0, 255), 2'b00};
            end
            if (k == LAT) idle_inputs();
        end
        chk({tag, " resp timing"}, 32'(hit_mine), 32'(1) << (LAT - 1));
        chk({tag, " other port"}, 32'(hit_other), 32'd0);
        if (store) begin
            mstore(a, m, d);
            chk({tag, " rdata held"}, bus.data_mem_rdata, rd_prev);
        end else begin
            chk({tag, " rdata"}, is_d ? bus.data_mem_rdata : bus.instr_mem_rdata, exp_rd);
        end
    endtask

    initial begin
        logic [15:0] dv, iv, edv, eiv;
        logic [7:0]  v;
        logic [31:0] old;
        bit          is_d, rd, wr;
        int          ix;
        idle_inputs();
        step(); step();
        chk("reset instr_resp", 32'(bus.instr_mem_resp), 32'd0);
        chk("reset data_resp", 32'(bus.data_mem_resp), 32'd0);
        chk("reset instr_rdata", bus.instr_mem_rdata, 32'd0);
        chk("reset data_rdata", bus.data_mem_rdata, 32'd0);
        chk("reset mem_err", 32'(mem_err), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) xact("init", 1, 0, 1, 4'hF, 32'(i * 4), $urandom);
        xact("init 0x100", 1, 0, 1, 4'hF, 32'h100, $urandom);
        xact("store deadbeef", 1, 0, 1, 4'hF, 32'h40, 32'hDEADBEEF);
        xact("load deadbeef", 1, 1, 0, 4'h0, 32'h40, 32'h0);
        chk("deadbeef value", bus.data_mem_rdata, 32'hDEADBEEF);
        xact("store 11223344", 1, 0, 1, 4'hF, 32'h40, 32'h11223344);
        xact("byte store", 1, 0, 1, 4'b0010, 32'h41, 32'h0000AB00);
        xact("load byte", 1, 1, 0, 4'h0, 32'h40, 32'h0);
        chk("byte merge value", bus.data_mem_rdata, 32'h1122AB44);
        xact("mbe zero store", 1, 0, 1, 4'b0000, 32'h40, 32'hFFFFFFFF);
        xact("load after mbe0", 1, 1, 0, 4'h0, 32'h40, 32'h0);
        xact("fetch 0x40", 0, 1, 0, 4'h0, 32'h40, 32'h0);
        // flush: fetch dropped in BUSY, new fetch of 0x100 the following cycle
        v = '0;
        bus.instr_read = 1'b1; bus.instr_mem_address = 32'h80;
        step(); v[1] = bus.instr_mem_resp; bus.instr_read = 1'b0;
        step(); v[2] = bus.instr_mem_resp; bus.instr_read = 1'b1; bus.instr_mem_address = 32'h100;
        for (int c = 3; c <= LAT + 3; c++) begin
            step(); v[c] = bus.instr_mem_resp;
            if (c == LAT + 2) idle_inputs();
        end
        chk("flush resp timing", 32'(v), 32'(1) << (LAT + 2));
        chk("flush rdata", bus.instr_mem_rdata, model[64]);
        for (int n = 0; n < 40; n++) begin
            is_d = $urandom_range(0, 2) != 0;
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            ix = $urandom_range(0, 31);
            xact("random", is_d, rd, wr, 4'($urandom), 32'(ix * 4) | (is_d ? 32'($urandom_range(0, 3)) : 32'd0), $urandom);
        end
        // reset during BUSY cancels the store
        old = model[5];
        bus.data_write = 1'b1; bus.data_mbe = 4'hF; bus.data_mem_address = 32'd20; bus.data_mem_wdata = ~old;
        step();
        rst = 1'b0; #1;
        chk("rst busy data_resp", 32'(bus.data_mem_resp), 32'd0);
        chk("rst busy data_rdata", bus.data_mem_rdata, 32'd0);
        idle_inputs(); step(); rst = 1'b1;
        xact("rst busy reload", 1, 1, 0, 4'h0, 32'd20, 32'h0);
        // reset during RESP also cancels the store
        old = model[6];
        bus.data_write = 1'b1; bus.data_mbe = 4'hF; bus.data_mem_address = 32'd24; bus.data_mem_wdata = ~old;
        for (int c = 1; c <= LAT; c++) step();
        chk("pre-rst resp", 32'(bus.data_mem_resp), 32'd1);
        rst = 1'b0; #1;
        chk("rst resp data_resp", 32'(bus.data_mem_resp), 32'd0);
        idle_inputs(); step(); rst = 1'b1;
        // tie held from reset: services alternate data, instr, data, instr
        dv = '0; iv = '0; edv = '0; eiv = '0;
        for (int n = 0; n < 4; n++)
            if (n % 2 == 0) edv[n*(LAT+1)+LAT] = 1'b1;
            else eiv[n*(LAT+1)+LAT] = 1'b1;
        bus.instr_read = 1'b1; bus.instr_mem_address = 32'h0;
        bus.data_read = 1'b1; bus.data_mem_address = 32'h40;
        for (int c = 1; c <= 4 * LAT + 4; c++) begin
            step();
            dv[c] = bus.data_mem_resp;
            iv[c] = bus.instr_mem_resp;
        end
        idle_inputs();
        chk("tie data resp cycles", 32'(dv), 32'(edv));
        chk("tie instr resp cycles", 32'(iv), 32'(eiv));
        chk("tie instr rdata", bus.instr_mem_rdata, model[0]);
        chk("tie data rdata", bus.data_mem_rdata, model[16]);
        step();
        xact("rst resp reload", 1, 1, 0, 4'h0, 32'd24, 32'h0);
        chk("rst resp old value", bus.data_mem_rdata, old);
        xact("read+write store", 1, 1, 1, 4'hF, 32'h44, 32'hCAFEF00D);
        xact("load rw", 1, 1, 0, 4'h0, 32'h44, 32'h0);
        xact("alias store", 1, 0, 1, 4'b1001, 32'hFFFFF04C, 32'hA5B6C7D8);
        xact("alias load", 1, 1, 0, 4'h0, 32'h4C, 32'h0);
`ifdef MEM_ERR_CHK_EN
        chk("mem_err sticky", 32'(mem_err), 32'd1);
`else
        chk("mem_err tied", 32'(mem_err), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Memory-side responder for the core's instruction and data request ports (read/write/mbe/address/wdata in; resp/rdata out).
- Arbitrates both ports onto one single-ported word array of parameterizable depth, with configurable fixed latency.
- Used as the core's backing store in simulation and as the on-chip scratch memory in FPGA builds.

Parameters:
- ADDR_WIDTH, 10, word-index bits; depth = 2^ADDR_WIDTH words.
- LATENCY, 2, cycles from request accept to resp pulse; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_read  in  1  instruction fetch request; held by the core until resp or a flush drop.
- instr_mem_address  in  32  fetch byte address.
- instr_mem_resp  out  1  one-cycle fetch completion pulse.
- instr_mem_rdata  out  32  fetched word; valid when instr_mem_resp=1.
- data_read  in  1  load request.
- data_write  in  1  store request.
- data_mbe  in  4  store byte enables; bit i enables byte lane i.
- data_mem_address  in  32  data byte address.
- data_mem_wdata  in  32  store data, already lane-aligned by the core.
- data_mem_resp  out  1  one-cycle data completion pulse, for loads and stores.
- data_mem_rdata  out  32  loaded word; valid when data_mem_resp=1.
- mem_err  out  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; resp outputs, rdata outputs and mem_err go to 0.
  - Arbitration pointer set to favour data.
  - Array contents are not reset.
  - Reset during BUSY or RESP drops the transaction; no write occurs.
- Word index is addr[ADDR_WIDTH+1:2]. addr[1:0] and the upper bits are ignored, so out-of-range addresses alias.
- FSM states:
  - IDLE: if any request is pending, accept one, latch port select, index, mbe and wdata, load the counter with LATENCY-1, and go to BUSY.
  - BUSY: decrement the counter; at 0 go to RESP.
  - RESP: drive resp=1 for the latched port for exactly one cycle, then go to IDLE.
- Latency:
  - Request accepted in cycle T; resp is high in cycle T+LATENCY.
  - With LATENCY=1, BUSY is skipped: IDLE goes directly to RESP.
- Back-to-back: IDLE is never the same cycle as RESP, so a request presented in the cycle after resp is accepted then. Peak throughput is one access per LATENCY+1 cycles.
- Arbitration when both ports request in IDLE:
  - Round-robin: the port not served last wins.
  - After reset, data wins the first tie.
  - A lone requester is always accepted.
- Loads and fetches: the array is read in the RESP cycle, so a store that completed earlier is always visible. rdata is registered and holds its last value outside the resp pulse.
- Stores:
  - Byte lane i is written in the RESP cycle iff data_mbe[i]=1, using latched wdata[8i+7:8i].
  - data_mem_rdata is unchanged by a store.
  - data_mbe=0000 still completes with resp and writes nothing.
- Abort: if the latched port's request (read, or write for a store) deasserts while in BUSY, return to IDLE with no resp and no write. A request still asserted when entering RESP completes.
- Request fields are sampled only at accept; later changes to address, data or mbe are ignored.
- data_read and data_write both high is treated as a store.

Optional Feature:
- MEM_ERR_CHK_EN defined:
  - mem_err sets and stays set until reset if any of these occurs at accept: data_read&data_write; address bits above ADDR_WIDTH+1 nonzero; fetch address [1:0]!=0.
  - Also sets if the latched address changes while BUSY.
  - An $error is issued in simulation. Transaction behaviour is otherwise identical.
- Undefined: mem_err is tied to 0 and the checking logic is absent.

Test Plan:
- LATENCY=2: store 0xDEADBEEF, mbe=1111, addr 0x40, accepted cycle 0 -> data_mem_resp high in cycle 2 only. Then load 0x40 -> rdata 0xDEADBEEF two cycles after accept.
- Byte store: wdata 0x0000AB00, mbe=0010, addr 0x41 over existing word 0x11223344 -> subsequent load at 0x40 returns 0x1122AB44.
- Simultaneous fetch 0x0 and load 0x40, both held from reset -> data served first (resp cycle 2), fetch accepted cycle 3, instr_mem_resp cycle 5. Next tie goes to instr.
- Fetch accepted, instr_read dropped at BUSY (flush) -> no instr_mem_resp. A new fetch of 0x100 is accepted the following cycle and responds LATENCY later.
- rst pulled low during a store's BUSY -> resp outputs 0 immediately; a later load of that address shows the old contents.
- With MEM_ERR_CHK_EN: data_read=data_write=1 at accept -> mem_err=1 from the next cycle and stays 1 until reset. Without the macro -> mem_err stays 0.
